// File: rtl/dsmp_pkg.sv
// Shared definitions for the 2x2 down-sampling window address generator:
// bus width, FSM state encoding, tap position codes and a counter-width helper.
package dsmp_pkg;

    localparam int unsigned AW = 18;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } dsmp_state_e;

    localparam logic [1:0] TAP_TL = 2'd0;
    localparam logic [1:0] TAP_TR = 2'd1;
    localparam logic [1:0] TAP_BL = 2'd2;
    localparam logic [1:0] TAP_BR = 2'd3;

    // Counter width for n states; a single-state counter still needs one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dsmp_wrap_counter.sv
// Wrapping up-counter: counts 0..TERMINAL on i_inc and flags the increment that wraps.
// State updates on the falling clock edge; i_rst is synchronous, active-high.
module dsmp_wrap_counter #(
    parameter int unsigned WIDTH    = 1,
    parameter int unsigned TERMINAL = 0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_wrap
);

    logic [WIDTH-1:0] r_count;

    // Wrap is combinational so the caller sees it on the same handshake.
    assign o_wrap = i_inc && (r_count == WIDTH'(TERMINAL));

    // Count register: clear on reset or new pass, wrap to zero after TERMINAL.
    always_ff @(negedge i_clk) begin
        if (i_rst || i_clr) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= o_wrap ? '0 : r_count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/dsmp_window_addr_gen.sv
// Source-pixel address sequencer for a 2x2 down-sampling pass, output-row-major order.
// Emits TL, TR, BL, BR for each window over a valid/ready handshake using adders only.
// Optional build macro: DSMP_BOUND_CHK_EN enables the sticky address-wrap flag o_oob_err;
// when undefined o_oob_err is tied low and no carry logic exists.
// All state updates on the falling edge of i_clk; i_rst is synchronous, active-high.
module dsmp_window_addr_gen
    import dsmp_pkg::*;
#(
    parameter int unsigned IMG_W = 256,
    parameter int unsigned IMG_H = 256
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic [AW-1:0] i_base_addr,
    input  logic          i_addr_ready,
    output logic [AW-1:0] o_addr,
    output logic          o_addr_valid,
    output logic [1:0]    o_tap,
    output logic          o_last_tap,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_oob_err
);

    localparam int unsigned COL_W = cnt_width(IMG_W / 2);
    localparam int unsigned ROW_W = cnt_width(IMG_H / 2);

    dsmp_state_e   r_state;
    dsmp_state_e   w_state_next;
    logic [AW-1:0] r_addr;
    logic [AW-1:0] r_win_base;  // TL address of the current window
    logic [AW-1:0] r_row_base;  // TL address of the first window in the current output row
    logic [1:0]    r_tap;

    logic          w_start_acc;
    logic          w_hs;
    logic          w_tap_br;
    logic          w_col_inc;
    logic          w_col_wrap;
    logic          w_row_wrap;
    logic          w_final;
    logic [AW-1:0] w_opa;
    logic [AW-1:0] w_opb;
    logic [AW-1:0] w_sum;

    assign w_start_acc = (r_state == StIdle) && i_start;
    assign w_hs        = (r_state == StRun) && i_addr_ready;
    assign w_tap_br    = (r_tap == TAP_BR);
    assign w_col_inc   = w_hs && w_tap_br;
    assign w_final     = w_row_wrap;

    dsmp_wrap_counter #(
        .WIDTH    (COL_W),
        .TERMINAL (IMG_W / 2 - 1)
    ) u_col_cnt (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_clr  (w_start_acc),
        .i_inc  (w_col_inc),
        .o_wrap (w_col_wrap)
    );

    dsmp_wrap_counter #(
        .WIDTH    (ROW_W),
        .TERMINAL (IMG_H / 2 - 1)
    ) u_row_cnt (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_clr  (w_start_acc),
        .i_inc  (w_col_wrap),
        .o_wrap (w_row_wrap)
    );

    // FSM state register.
    always_ff @(negedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state: start only counts in idle; done lasts exactly one cycle.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (i_start) w_state_next = StRun;
            StRun:   if (w_final) w_state_next = StDone;
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // Operand select for the next address; a row change restarts from the row base.
    always_comb begin
        w_opa = r_win_base;
        w_opb = '0;
        unique case (r_tap)
            TAP_TL: w_opb = AW'(1);
            TAP_TR: w_opb = AW'(IMG_W);
            TAP_BL: w_opb = AW'(IMG_W + 1);
            TAP_BR: begin
                if (w_col_wrap) begin
                    w_opa = r_row_base;
                    w_opb = AW'(2 * IMG_W);
                end else begin
                    w_opb = AW'(2);
                end
            end
            default: w_opb = '0;
        endcase
    end

`ifdef DSMP_BOUND_CHK_EN
    logic [AW:0] w_sum_ext;
    logic        r_oob;

    assign w_sum_ext = {1'b0, w_opa} + {1'b0, w_opb};
    assign w_sum     = w_sum_ext[AW-1:0];
    assign o_oob_err = r_oob;

    // Sticky wrap flag: only sums that actually become emitted addresses count.
    always_ff @(negedge i_clk) begin
        if (i_rst || w_start_acc) begin
            r_oob <= 1'b0;
        end else if (w_hs && !w_final && w_sum_ext[AW]) begin
            r_oob <= 1'b1;
        end
    end
`else
    assign w_sum     = w_opa + w_opb;
    assign o_oob_err = 1'b0;
`endif

    // Address datapath: load base on start, advance one tap per handshake.
    always_ff @(negedge i_clk) begin
        if (i_rst) begin
            r_addr     <= '0;
            r_win_base <= '0;
            r_row_base <= '0;
            r_tap      <= TAP_TL;
        end else if (w_start_acc) begin
            r_addr     <= i_base_addr;
            r_win_base <= i_base_addr;
            r_row_base <= i_base_addr;
            r_tap      <= TAP_TL;
        end else if (w_hs) begin
            r_tap <= r_tap + 2'd1;
            // The sum after the final handshake would point past the image; keep it out.
            if (!w_final) begin
                r_addr <= w_sum;
                if (w_tap_br) begin
                    r_win_base <= w_sum;
                    if (w_col_wrap) begin
                        r_row_base <= w_sum;
                    end
                end
            end
        end
    end

    assign o_addr       = r_addr;
    assign o_addr_valid = (r_state == StRun);
    assign o_tap        = r_tap;
    assign o_last_tap   = (r_tap == TAP_BR);
    assign o_busy       = (r_state == StRun);
    assign o_done       = (r_state == StDone);

endmodule

// File: tb/tb_dsmp_window_addr_gen.sv
// Bench for dsmp_window_addr_gen (IMG_W=IMG_H=4). DUT acts on the falling edge, so the
// bench samples and drives on the rising edge. Expected addresses come from a closed-form
// window/tap formula; o_oob_err is expected only when DSMP_BOUND_CHK_EN is defined.
module tb_dsmp_window_addr_gen;
    import dsmp_pkg::*;

    localparam int unsigned IMG_W = 4;
    localparam int unsigned IMG_H = 4;
    localparam int unsigned NADDR = IMG_W * IMG_H;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic          addr_ready;
    logic [AW-1:0] addr;
    logic          addr_valid;
    logic [1:0]    tap;
    logic          last_tap;
    logic          busy;
    logic          done;
    logic          oob_err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dsmp_window_addr_gen #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_base_addr  (base_addr),
        .i_addr_ready (addr_ready),
        .o_addr       (addr),
        .o_addr_valid (addr_valid),
        .o_tap        (tap),
        .o_last_tap   (last_tap),
        .o_busy       (busy),
        .o_done       (done),
        .o_oob_err    (oob_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Unbounded address of the k-th emitted tap: window row/col from k, tap offset added.
    function automatic longint unsigned model_full(input logic [AW-1:0] base, input int k);
        longint unsigned win = longint'(k / 4);
        longint unsigned t   = longint'(k % 4);
        longint unsigned r   = win / (IMG_W / 2);
        longint unsigned c   = win % (IMG_W / 2);
        return longint'(base) + 2 * r * IMG_W + 2 * c + (t / 2) * IMG_W + (t % 2);
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, addr_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
    endtask

    // One pass. mode 0: ready always; 1: random ready; 2: ready low 3 cycles at stall_at.
    // poke: pulse start (base 100) mid-run and during done. abort_at>=0: reset at that tap.
    task automatic run_pass(input logic [AW-1:0] base, input int mode, input int stall_at,
                            input bit poke, input int abort_at);
        int k = 0;
        int cyc = 0;
        int stall = 0;
        bit exp_oob = 1'b0;
        bit rdy;
        longint unsigned full;
        base_addr  = base;
        start      = 1'b1;
        addr_ready = 1'b0;
        @(posedge clk);
        start     = 1'b0;
        base_addr = AW'($urandom);
        while (k < int'(NADDR) && cyc < 500) begin
            full = model_full(base, k);
            if ((full >> AW) != 0) exp_oob = 1'b1;
            check("valid", addr_valid, 1);
            check("addr", addr, 32'(full[AW-1:0]));
            check("tap", tap, k % 4);
            check("last_tap", last_tap, (k % 4) == 3);
            check("busy", busy, 1);
            check("done_early", done, 0);
`ifdef DSMP_BOUND_CHK_EN
            check("oob", oob_err, exp_oob);
`else
            check("oob", oob_err, 0);
`endif
            if (k == abort_at) begin
                rst        = 1'b1;
                addr_ready = 1'b1;
                @(posedge clk);
                rst = 1'b0;
                check_idle("abort");
                check("abort_addr", addr, 0);
                check("abort_tap", tap, 0);
                check("abort_oob", oob_err, 0);
                @(posedge clk);
                check_idle("abort_after");
                return;
            end
            case (mode)
                1:       rdy = ($urandom_range(0, 99) < 70);
                2:       rdy = !(k == stall_at && stall < 3);
                default: rdy = 1'b1;
            endcase
            if (!rdy && mode == 2) stall++;
            start      = poke && (k == 5);
            base_addr  = start ? AW'(100) : base_addr;
            addr_ready = rdy;
            @(posedge clk);
            cyc++;
            if (rdy) k++;
        end
        start = 1'b0;
        check("handshake_count", k, NADDR);
        check("done_pulse", done, 1);
        check("done_valid", addr_valid, 0);
        check("done_busy", busy, 0);
`ifdef DSMP_BOUND_CHK_EN
        check("done_oob", oob_err, exp_oob);
`else
        check("done_oob", oob_err, 0);
`endif
        addr_ready = 1'($urandom);
        start      = poke;
        base_addr  = AW'(100);
        @(posedge clk);
        start = 1'b0;
        check_idle("post_done");
        @(posedge clk);
        check_idle("post_done2");
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        base_addr  = '0;
        addr_ready = 1'b0;
        repeat (2) @(posedge clk);
        check_idle("reset");
        check("reset_addr", addr, 0);
        check("reset_tap", tap, 0);
        check("reset_last", last_tap, 0);
        check("reset_oob", oob_err, 0);
        rst = 1'b0;
        @(posedge clk);

        // Nominal sequence from base 2 with continuous ready.
        run_pass(AW'(2), 0, -1, 1'b0, -1);
        // Backpressure at tap 2 (address 6).
        run_pass(AW'(2), 2, 2, 1'b0, -1);
        // Start pulses in RUN and DONE are ignored.
        run_pass(AW'(2), 0, -1, 1'b1, -1);
        // Reset on the fifth address, then restart from base 0.
        run_pass(AW'(2), 0, -1, 1'b0, 4);
        run_pass(AW'(0), 0, -1, 1'b0, -1);
        // Address wrap near the top of the space.
        run_pass(AW'(18'h3FFFE), 0, -1, 1'b0, -1);
        // Random bases and random ready; one pass straddles the wrap point.
        run_pass(AW'(18'h3FFFF - $urandom_range(0, 20)), 1, -1, 1'b0, -1);
        for (int p = 0; p < 4; p++) begin
            run_pass(AW'($urandom), 1, -1, 1'b0, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
